mprj_io_config: RTL and testbench

MPRJ_IO_CONFIG -- requirements
Module: mprj_io_config

---
 rtl/mprj_io_pkg.sv | 23 ++
 rtl/mprj_io_chain_ser.sv | 42 ++++
 rtl/mprj_io_config.sv | 194 +++++++++++++++++++
 tb/tb_mprj_io_config.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_io_pkg.sv
// Shared types and constants for the user-project GPIO configuration block.
// Holds the transfer FSM encoding and the chain-length helper.
package mprj_io_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLoad  = 2'd2,
    StDone  = 2'd3
  } xfer_state_e;

  localparam int unsigned CFG_BITS_DEF = 13;
  localparam logic [12:0] CFG_INIT_DEF = 13'h0403;

  // Pad slots shifted per chain: the longer of the two chains sets the length.
  function automatic int unsigned chain_len(input int unsigned total_pads,
                                            input int unsigned area1_pads);
    int unsigned area2_pads;
    area2_pads = total_pads - area1_pads;
    return (area1_pads > area2_pads) ? area1_pads : area2_pads;
  endfunction

endpackage

// File: rtl/mprj_io_chain_ser.sv
// Serial bit selector for one GPIO configuration chain: maps (slot, bit) to the
// pad word, inserting leading zero slots when this chain is the shorter one.
module mprj_io_chain_ser
  import mprj_io_pkg::*;
#(
  parameter int unsigned TotalPads  = 38,
  parameter int unsigned CfgBits    = CFG_BITS_DEF,
  parameter int unsigned Base       = 0,
  parameter int unsigned NumPads    = 19,
  parameter int unsigned NumSlots   = 19,
  parameter bit          Descending = 1'b0,
  parameter int unsigned SlotW      = 5,
  parameter int unsigned BitW       = 4
) (
  input  logic [CfgBits-1:0] words_i [TotalPads],
  input  logic [SlotW-1:0]   slot_i,
  input  logic [BitW-1:0]    bit_i,
  output logic               data_o
);

  localparam int unsigned PadSlots = NumSlots - NumPads;
  localparam int unsigned IdxW     = $clog2(TotalPads);

  int unsigned       rel;
  int unsigned       idx;
  logic [CfgBits-1:0] word;

  always_comb begin
    rel    = 0;
    idx    = Base;
    word   = '0;
    data_o = 1'b0;
    if (32'(slot_i) >= PadSlots) begin
      rel    = 32'(slot_i) - PadSlots;
      idx    = Descending ? (Base + NumPads - 1 - rel) : (Base + rel);
      word   = words_i[IdxW'(idx)];
      // bit_i counts up from 0, words go out MSB first
      data_o = word[BitW'(CfgBits - 1 - 32'(bit_i))];
    end
  end

endmodule

// File: rtl/mprj_io_config.sv
// GPIO pad configuration shadow registers with a dual-chain serial loader.
// Shadows are written over a simple bus and shifted out on xfer, then latched.
module mprj_io_config
  import mprj_io_pkg::*;
#(
  parameter int unsigned          TOTAL_PADS = 38,
  parameter int unsigned          AREA1PADS  = 19,
  parameter int unsigned          CFG_BITS   = CFG_BITS_DEF,
  parameter logic [CFG_BITS-1:0]  CFG_INIT   = CFG_INIT_DEF
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          cfg_we,
  input  logic [$clog2(TOTAL_PADS)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]           cfg_wdata,
  output logic [CFG_BITS-1:0]           cfg_rdata,
  input  logic                          xfer,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          serial_clock,
  output logic                          serial_load,
  output logic                          serial_data_1,
  output logic                          serial_data_2
);

  localparam int unsigned L     = chain_len(TOTAL_PADS, AREA1PADS);
  localparam int unsigned SlotW = $clog2(L + 1);
  localparam int unsigned BitW  = $clog2(CFG_BITS);

  localparam logic [SlotW-1:0] LastSlot = SlotW'(L - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(CFG_BITS - 1);

  xfer_state_e       state_q, state_d;
  logic              phase_q, phase_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic              load_cnt_q, load_cnt_d;

  logic [CFG_BITS-1:0] shadow_q [TOTAL_PADS];
  logic [CFG_BITS-1:0] shadow_d [TOTAL_PADS];

  logic [CFG_BITS-1:0] rdata_q;
  logic busy_q, done_q, err_q, sclk_q, load_q, data1_q, data2_q;

  logic addr_ok, we_ok, xfer_ok, err_set;
  logic ser1, ser2;

  always_comb begin
    addr_ok = 32'(cfg_addr) < TOTAL_PADS;
    we_ok   = cfg_we && addr_ok && (state_q == StIdle);
    xfer_ok = xfer && (state_q == StIdle);
    err_set = (cfg_we && !we_ok) || (xfer && (state_q != StIdle));
  end

  // Writes are only accepted in idle, so the shadows stay frozen for the whole
  // transfer and act as its snapshot. A same-cycle write is visible to slot 0.
  always_comb begin
    shadow_d = shadow_q;
    if (we_ok) begin
      shadow_d[cfg_addr] = cfg_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    slot_d     = slot_q;
    load_cnt_d = load_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d = StShift;
          phase_d = 1'b0;
          bit_d   = '0;
          slot_d  = '0;
        end
      end
      StShift: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (bit_q == LastBit) begin
            bit_d = '0;
            if (slot_q == LastSlot) begin
              slot_d     = '0;
              state_d    = StLoad;
              load_cnt_d = 1'b0;
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StLoad: begin
        if (load_cnt_q) begin
          state_d    = StDone;
          load_cnt_d = 1'b0;
        end else begin
          load_cnt_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  mprj_io_chain_ser #(
    .TotalPads (TOTAL_PADS),
    .CfgBits   (CFG_BITS),
    .Base      (0),
    .NumPads   (AREA1PADS),
    .NumSlots  (L),
    .Descending(1'b1),
    .SlotW     (SlotW),
    .BitW      (BitW)
  ) u_chain1 (
    .words_i(shadow_d),
    .slot_i (slot_d),
    .bit_i  (bit_d),
    .data_o (ser1)
  );

  mprj_io_chain_ser #(
    .TotalPads (TOTAL_PADS),
    .CfgBits   (CFG_BITS),
    .Base      (AREA1PADS),
    .NumPads   (TOTAL_PADS - AREA1PADS),
    .NumSlots  (L),
    .Descending(1'b0),
    .SlotW     (SlotW),
    .BitW      (BitW)
  ) u_chain2 (
    .words_i(shadow_d),
    .slot_i (slot_d),
    .bit_i  (bit_d),
    .data_o (ser2)
  );

  // Outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      slot_q     <= '0;
      load_cnt_q <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sclk_q     <= 1'b0;
      load_q     <= 1'b0;
      data1_q    <= 1'b0;
      data2_q    <= 1'b0;
      for (int i = 0; i < int'(TOTAL_PADS); i++) begin
        shadow_q[i] <= CFG_INIT;
      end
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      slot_q     <= slot_d;
      load_cnt_q <= load_cnt_d;
      shadow_q   <= shadow_d;
      rdata_q    <= addr_ok ? shadow_q[cfg_addr] : '0;
      busy_q     <= (state_d == StShift) || (state_d == StLoad);
      done_q     <= (state_d == StDone);
      load_q     <= (state_d == StLoad);
      sclk_q     <= (state_d == StShift) && phase_d;
      data1_q    <= (state_d == StShift) && ser1;
      data2_q    <= (state_d == StShift) && ser2;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (xfer_ok) begin
        err_q <= 1'b0;
      end
    end
  end

  assign cfg_rdata     = rdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign serial_clock  = sclk_q;
  assign serial_load   = load_q;
  assign serial_data_1 = data1_q;
  assign serial_data_2 = data2_q;

endmodule

// File: tb/tb_mprj_io_config.sv
// Scoreboard bench: two instances (19/19 and 20/18 chain splits) share stimulus;
// expected serial streams are queued at xfer and popped on each serial_clock rise.
module tb_mprj_io_config;

  localparam int          TP   = 38;
  localparam logic [12:0] INIT = 13'h0403;

  logic        clock = 1'b0;
  logic        resetn, cfg_we, xfer;
  logic [5:0]  cfg_addr;
  logic [12:0] cfg_wdata;

  logic [12:0] rdata_a, rdata_b;
  logic busy_a, done_a, err_a, sclk_a, load_a, d1_a, d2_a;
  logic busy_b, done_b, err_b, sclk_b, load_b, d1_b, d2_b;

  always #5 clock = ~clock;

  mprj_io_config #(.TOTAL_PADS(38), .AREA1PADS(19)) dut_a (
    .clock(clock), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(rdata_a), .xfer(xfer), .busy(busy_a),
    .done(done_a), .err(err_a), .serial_clock(sclk_a), .serial_load(load_a),
    .serial_data_1(d1_a), .serial_data_2(d2_a)
  );

  mprj_io_config #(.TOTAL_PADS(38), .AREA1PADS(20)) dut_b (
    .clock(clock), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(rdata_b), .xfer(xfer), .busy(busy_b),
    .done(done_b), .err(err_b), .serial_clock(sclk_b), .serial_load(load_b),
    .serial_data_1(d1_b), .serial_data_2(d2_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] model [TP];
  bit q1a[$], q2a[$], q1b[$], q2b[$];
  logic sclk_a_prev = 1'b0, sclk_b_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected chain streams for a given chain-1 pad count, from the model shadows.
  task automatic push_all();
    for (int area1 = 19; area1 <= 20; area1++) begin
      int l, n2, p1, p2;
      bit c1, c2;
      n2 = TP - area1;
      l  = (area1 > n2) ? area1 : n2;
      for (int s = 0; s < l; s++) begin
        for (int b = 12; b >= 0; b--) begin
          p1 = s - (l - area1);
          p2 = s - (l - n2);
          c1 = (p1 >= 0) ? model[area1 - 1 - p1][b] : 1'b0;
          c2 = (p2 >= 0) ? model[area1 + p2][b] : 1'b0;
          if (area1 == 19) begin
            q1a.push_back(c1);
            q2a.push_back(c2);
          end else begin
            q1b.push_back(c1);
            q2b.push_back(c2);
          end
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (sclk_a && !sclk_a_prev) begin
      check("a_bit_expected", 32'((q1a.size() != 0) && (q2a.size() != 0)), 1);
      if (q1a.size() != 0 && q2a.size() != 0) begin
        check("a_chain1_bit", d1_a, q1a.pop_front());
        check("a_chain2_bit", d2_a, q2a.pop_front());
      end
    end
    if (sclk_b && !sclk_b_prev) begin
      check("b_bit_expected", 32'((q1b.size() != 0) && (q2b.size() != 0)), 1);
      if (q1b.size() != 0 && q2b.size() != 0) begin
        check("b_chain1_bit", d1_b, q1b.pop_front());
        check("b_chain2_bit", d2_b, q2b.pop_front());
      end
    end
    sclk_a_prev = sclk_a;
    sclk_b_prev = sclk_b;
  end

  task automatic write(input logic [5:0] addr, input logic [12:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(negedge clock);
    cfg_we = 1'b0;
    if (addr < TP) model[addr] = data;
  endtask

  task automatic read_chk(input string tag, input logic [5:0] addr);
    logic [12:0] exp;
    exp      = (addr < TP) ? model[addr] : 13'h0;
    cfg_addr = addr;
    @(negedge clock);
    check($sformatf("%s_a", tag), rdata_a, exp);
    check($sformatf("%s_b", tag), rdata_b, exp);
  endtask

  // Runs one transfer over a fixed cycle budget; optionally writes in the same
  // cycle as xfer, or injects a write and an xfer while the chain is busy.
  task automatic run_xfer(input string tag, input bit with_we, input logic [5:0] waddr,
                          input logic [12:0] wdata, input bit inject);
    int busy_na, busy_nb, load_na, load_nb, done_na, done_nb, done_at_a, done_at_b;
    busy_na = 0; busy_nb = 0; load_na = 0; load_nb = 0;
    done_na = 0; done_nb = 0; done_at_a = -1; done_at_b = -1;
    if (with_we) begin
      model[waddr] = wdata;
      cfg_we    = 1'b1;
      cfg_addr  = waddr;
      cfg_wdata = wdata;
    end
    push_all();
    xfer = 1'b1;
    @(negedge clock);
    xfer   = 1'b0;
    cfg_we = 1'b0;
    for (int cyc = 0; cyc < 540; cyc++) begin
      if (busy_a) busy_na++;
      if (busy_b) busy_nb++;
      if (load_a) load_na++;
      if (load_b) load_nb++;
      if (done_a) begin done_na++; if (done_at_a < 0) done_at_a = cyc; end
      if (done_b) begin done_nb++; if (done_at_b < 0) done_at_b = cyc; end
      if (inject && cyc == 10) begin
        cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 13'h1F0F;
      end
      if (inject && cyc == 11) begin
        cfg_we = 1'b0; xfer = 1'b1;
      end
      if (inject && cyc == 12) xfer = 1'b0;
      @(negedge clock);
    end
    check({tag, "_busy_a"}, busy_na, 496);
    check({tag, "_busy_b"}, busy_nb, 522);
    check({tag, "_load_a"}, load_na, 2);
    check({tag, "_load_b"}, load_nb, 2);
    check({tag, "_done_a"}, done_na, 1);
    check({tag, "_done_b"}, done_nb, 1);
    check({tag, "_done_at_a"}, done_at_a, 496);
    check({tag, "_done_at_b"}, done_at_b, 522);
    check({tag, "_drained_a"}, q1a.size() + q2a.size(), 0);
    check({tag, "_drained_b"}, q1b.size() + q2b.size(), 0);
    check({tag, "_err_a"}, err_a, inject);
    check({tag, "_err_b"}, err_b, inject);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_outs_a"}, {busy_a, done_a, err_a, sclk_a, load_a, d1_a, d2_a}, 0);
    check({tag, "_outs_b"}, {busy_b, done_b, err_b, sclk_b, load_b, d1_b, d2_b}, 0);
    check({tag, "_rdata_a"}, rdata_a, 0);
    check({tag, "_rdata_b"}, rdata_b, 0);
  endtask

  initial begin
    int load_seen;
    resetn = 1'b0; cfg_we = 1'b0; xfer = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    for (int i = 0; i < TP; i++) model[i] = INIT;
    repeat (3) @(negedge clock);
    check_quiet("reset");
    resetn = 1'b1;
    @(negedge clock);
    read_chk("rd_init0", 6'd0);
    read_chk("rd_init37", 6'd37);

    run_xfer("x_init", 1'b0, '0, '0, 1'b0);

    write(6'd38, 13'h0AAA);
    check("oob_err_a", err_a, 1);
    check("oob_err_b", err_b, 1);
    read_chk("rd_oob38", 6'd38);
    read_chk("rd_37_after_oob", 6'd37);
    read_chk("rd_0_after_oob", 6'd0);

    write(6'd20, 13'h1FFF);
    write(6'd3, 13'h0ABC);
    write(6'd37, 13'h1555);
    write(6'd18, 13'h0F0F);
    read_chk("rd_20", 6'd20);
    read_chk("rd_3", 6'd3);
    run_xfer("x_pattern", 1'b0, '0, '0, 1'b0);

    run_xfer("x_inject", 1'b0, '0, '0, 1'b1);
    read_chk("rd_5_unchanged", 6'd5);

    run_xfer("x_same_cycle", 1'b1, 6'd0, 13'h1234, 1'b0);
    read_chk("rd_0_new", 6'd0);

    // Abort a transfer with reset deep inside the shift phase
    push_all();
    xfer = 1'b1;
    @(negedge clock);
    xfer = 1'b0;
    load_seen = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (load_a || load_b) load_seen++;
      @(negedge clock);
    end
    check("abort_mid_busy_a", busy_a, 1);
    #2 resetn = 1'b0;
    #1 check_quiet("abort");
    q1a.delete(); q2a.delete(); q1b.delete(); q2b.delete();
    for (int i = 0; i < TP; i++) model[i] = INIT;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clock);
      if (load_a || load_b) load_seen++;
    end
    resetn = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clock);
      if (load_a || load_b) load_seen++;
    end
    check("abort_no_load", load_seen, 0);
    read_chk("rd_0_after_abort", 6'd0);
    run_xfer("x_after_abort", 1'b0, '0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
